led_sequencer: RTL and testbench

- Controller that drives the four Go Board LEDs from the four push-buttons.
- Each switch passes through a debouncer. A button release (debounced 1->0) is a command event.
- Switch 1 cycles the display mode. Switches 2-4 set speed, direction and pause, or toggle individual LEDs in manual mode.
- Sits at top level, between the raw switch pins and the LED pins.

---
 rtl/led_sequencer_pkg.sv | 38 +++
 rtl/debounce_filter.sv | 39 +++
 rtl/led_sequencer.sv | 112 +++++++++++
 tb/tb_led_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/led_sequencer_pkg.sv
// rtl/led_sequencer_pkg.sv - mode encodings, entry patterns and default timing for led_sequencer
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_MANUAL = 2'd3
  } mode_t;

  // Patterns are {LED_4, LED_3, LED_2, LED_1}.
  localparam logic [3:0] PAT_OFF    = 4'b0000;
  localparam logic [3:0] PAT_CHASE  = 4'b0001;
  localparam logic [3:0] PAT_BLINK  = 4'b1111;
  localparam logic [3:0] PAT_MANUAL = 4'b1000;

  localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
  localparam int DEFAULT_STEP_TICKS     = 6250000;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:    next_mode = MODE_CHASE;
      MODE_CHASE:  next_mode = MODE_BLINK;
      MODE_BLINK:  next_mode = MODE_MANUAL;
      default:     next_mode = MODE_OFF;
    endcase
  endfunction

  function automatic logic [3:0] entry_pattern(input mode_t m);
    case (m)
      MODE_CHASE:  entry_pattern = PAT_CHASE;
      MODE_BLINK:  entry_pattern = PAT_BLINK;
      MODE_MANUAL: entry_pattern = PAT_MANUAL;
      default:     entry_pattern = PAT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - per-switch debouncer with a registered one-cycle release pulse
module debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_Stable,
  output logic o_Release
);

  localparam int CW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic [CW-1:0] count;
  logic          stable_d;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_Stable  <= 1'b0;
      stable_d  <= 1'b0;
      o_Release <= 1'b0;
      count     <= '0;
    end else begin
      stable_d  <= o_Stable;
      o_Release <= stable_d & ~o_Stable;
      // Any return to the stable level throws away the accumulated count.
      if (i_Raw == o_Stable) begin
        count <= '0;
      end else if (count == LAST) begin
        o_Stable <= i_Raw;
        count    <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - Go Board LED pattern controller driven by four debounced buttons
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int STEP_TICKS     = DEFAULT_STEP_TICKS
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode,
  output logic       o_Paused
);

  localparam int CW = $clog2(STEP_TICKS);
  localparam logic [CW-1:0] SLOW_LAST = CW'(STEP_TICKS - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(STEP_TICKS / 2 - 1);

  logic [3:0]    raw;
  logic [3:0]    rel;
  logic [3:0]    unused_stable;
  mode_t         mode;
  logic [3:0]    led;
  logic          fast;
  logic          reverse;
  logic          paused;
  logic [CW-1:0] step_cnt;
  logic [CW-1:0] step_last;
  logic          running;
  logic          tick;

  assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    debounce_filter #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_deb (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .i_Raw    (raw[i]),
      .o_Stable (unused_stable[i]),
      .o_Release(rel[i])
    );
  end

  always_comb begin
    step_last = fast ? FAST_LAST : SLOW_LAST;
    running   = ((mode == MODE_CHASE) || (mode == MODE_BLINK)) && !paused;
    tick      = running && (step_cnt == step_last);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      mode     <= MODE_OFF;
      led      <= PAT_OFF;
      fast     <= 1'b0;
      reverse  <= 1'b0;
      paused   <= 1'b0;
      step_cnt <= '0;
    end else if (rel[0]) begin
      // Mode advance wins: other releases and a coincident tick are dropped.
      mode     <= next_mode(mode);
      led      <= entry_pattern(next_mode(mode));
      step_cnt <= '0;
    end else begin
      case (mode)
        MODE_CHASE, MODE_BLINK: begin
          fast    <= fast ^ rel[1];
          reverse <= reverse ^ rel[2];
          paused  <= paused ^ rel[3];
          if (rel[1] || tick) begin
            step_cnt <= '0;
          end else if (!paused) begin
            step_cnt <= step_cnt + 1'b1;
          end
          // The step uses the direction in force before any toggle this cycle.
          if (tick) begin
            if (mode == MODE_BLINK) begin
              led <= ~led;
            end else if (reverse) begin
              led <= {led[0], led[3:1]};
            end else begin
              led <= {led[2:0], led[3]};
            end
          end
        end
        MODE_MANUAL: begin
          led[3:1] <= led[3:1] ^ rel[3:1];
          step_cnt <= '0;
        end
        default: begin
          step_cnt <= '0;
        end
      endcase
    end
  end

  assign o_LED_1  = led[0];
  assign o_LED_2  = led[1];
  assign o_LED_3  = led[2];
  assign o_LED_4  = led[3];
  assign o_Mode   = mode;
  assign o_Paused = paused;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - directed scoreboard bench for led_sequencer (DEBOUNCE_LIMIT=4, STEP_TICKS=8)
module tb_led_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Switch_1 = 1'b0;
  logic       i_Switch_2 = 1'b0;
  logic       i_Switch_3 = 1'b0;
  logic       i_Switch_4 = 1'b0;
  logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4;
  logic [1:0] o_Mode;
  logic       o_Paused;
  logic [3:0] leds;

  typedef struct {
    string      tag;
    logic [1:0] mode;
    logic [3:0] led;
    logic       paused;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  led_sequencer #(
    .DEBOUNCE_LIMIT(4),
    .STEP_TICKS    (8)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_Switch_1(i_Switch_1),
    .i_Switch_2(i_Switch_2),
    .i_Switch_3(i_Switch_3),
    .i_Switch_4(i_Switch_4),
    .o_LED_1   (o_LED_1),
    .o_LED_2   (o_LED_2),
    .o_LED_3   (o_LED_3),
    .o_LED_4   (o_LED_4),
    .o_Mode    (o_Mode),
    .o_Paused  (o_Paused)
  );

  assign leds = {o_LED_4, o_LED_3, o_LED_2, o_LED_1};

  always #5 i_Clk = ~i_Clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic set_sw(input logic [3:0] mask);
    {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1} = mask;
  endtask

  task automatic push_exp(input string tag, input logic [1:0] m, input logic [3:0] l, input logic p);
    exp_t e;
    e.tag = tag;
    e.mode = m;
    e.led = l;
    e.paused = p;
    sb.push_back(e);
  endtask

  task automatic check_next();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_underflow: observed empty scoreboard, expected an entry");
    end else begin
      e = sb.pop_front();
      assert ({o_Mode, leds, o_Paused} === {e.mode, e.led, e.paused}) else begin
        failures++;
        $error("FAIL %s: observed mode=%0d led=%b paused=%b, expected mode=%0d led=%b paused=%b",
               e.tag, o_Mode, leds, o_Paused, e.mode, e.led, e.paused);
      end
    end
  endtask

  task automatic expect_after(input int n, input string tag, input logic [1:0] m,
                              input logic [3:0] l, input logic p);
    push_exp(tag, m, l, p);
    cyc(n);
    check_next();
  endtask

  // Press for 'hold' cycles, release; the command lands 6 edges after the release is driven.
  task automatic release_sw(input logic [3:0] mask, input int hold, input string tag,
                            input logic [1:0] m, input logic [3:0] l, input logic p);
    set_sw(mask);
    cyc(hold);
    set_sw(4'b0000);
    expect_after(6, tag, m, l, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    expect_after(2, "reset", 2'd0, 4'b0000, 1'b0);
    i_Rst_L = 1'b1;

    // Mode advance lands exactly 2 cycles after the release is accepted.
    set_sw(4'b0001);
    cyc(10);
    set_sw(4'b0000);
    expect_after(5, "pre_advance", 2'd0, 4'b0000, 1'b0);
    expect_after(1, "chase_entry", 2'd1, 4'b0001, 1'b0);
    expect_after(7, "chase_hold", 2'd1, 4'b0001, 1'b0);
    expect_after(1, "chase_step", 2'd1, 4'b0010, 1'b0);
    expect_after(24, "chase_wrap", 2'd1, 4'b0001, 1'b0);

    // Speed, direction, pause in CHASE.
    release_sw(4'b0010, 11, "fast_toggle", 2'd1, 4'b0100, 1'b0);
    expect_after(3, "fast_hold", 2'd1, 4'b0100, 1'b0);
    expect_after(1, "fast_step", 2'd1, 4'b1000, 1'b0);
    release_sw(4'b0100, 7, "dir_toggle", 2'd1, 4'b0100, 1'b0);
    expect_after(2, "dir_hold", 2'd1, 4'b0100, 1'b0);
    expect_after(1, "reverse_step", 2'd1, 4'b0010, 1'b0);
    release_sw(4'b1000, 11, "pause_on", 2'd1, 4'b0010, 1'b1);
    expect_after(50, "pause_hold", 2'd1, 4'b0010, 1'b1);
    release_sw(4'b1010, 10, "resume_slow", 2'd1, 4'b0010, 1'b0);
    expect_after(7, "slow_hold", 2'd1, 4'b0010, 1'b0);
    expect_after(1, "slow_reverse", 2'd1, 4'b0001, 1'b0);

    // BLINK, MANUAL, OFF.
    release_sw(4'b0001, 10, "blink_entry", 2'd2, 4'b1111, 1'b0);
    expect_after(7, "blink_hold", 2'd2, 4'b1111, 1'b0);
    expect_after(1, "blink_step", 2'd2, 4'b0000, 1'b0);
    release_sw(4'b0001, 10, "manual_entry", 2'd3, 4'b1000, 1'b0);
    expect_after(20, "manual_static", 2'd3, 4'b1000, 1'b0);
    release_sw(4'b0010, 10, "manual_sw2", 2'd3, 4'b1010, 1'b0);
    release_sw(4'b1100, 10, "manual_sw34", 2'd3, 4'b0110, 1'b0);
    release_sw(4'b0001, 10, "off_entry", 2'd0, 4'b0000, 1'b0);
    release_sw(4'b1000, 10, "off_ignore", 2'd0, 4'b0000, 1'b0);

    // Bouncing release of Switch 1 yields exactly one advance.
    set_sw(4'b0001);
    cyc(10);
    for (int b = 0; b < 2; b++) begin
      set_sw(4'b0000);
      cyc(2);
      set_sw(4'b0001);
      cyc(2);
    end
    expect_after(6, "bounce_none", 2'd0, 4'b0000, 1'b0);
    set_sw(4'b0000);
    expect_after(5, "bounce_pre", 2'd0, 4'b0000, 1'b0);
    expect_after(1, "bounce_advance", 2'd1, 4'b0001, 1'b0);
    expect_after(8, "reverse_persist", 2'd1, 4'b1000, 1'b0);
    expect_after(12, "single_advance", 2'd1, 4'b0100, 1'b0);

    // Switch 1 and Switch 3 together: direction must stay reverse.
    release_sw(4'b0101, 10, "sw1_priority", 2'd2, 4'b1111, 1'b0);
    release_sw(4'b0001, 10, "cycle_manual", 2'd3, 4'b1000, 1'b0);
    release_sw(4'b0001, 10, "cycle_off", 2'd0, 4'b0000, 1'b0);
    release_sw(4'b0001, 10, "cycle_chase", 2'd1, 4'b0001, 1'b0);
    expect_after(8, "dir_unchanged", 2'd1, 4'b1000, 1'b0);

    // Reset mid-BLINK with Switch 1 partly debounced.
    release_sw(4'b0001, 10, "blink_again", 2'd2, 4'b1111, 1'b0);
    cyc(3);
    set_sw(4'b0001);
    cyc(2);
    i_Rst_L = 1'b0;
    expect_after(1, "mid_reset", 2'd0, 4'b0000, 1'b0);
    i_Rst_L = 1'b1;
    cyc(3);
    set_sw(4'b0000);
    expect_after(10, "partial_discard", 2'd0, 4'b0000, 1'b0);
    release_sw(4'b0001, 4, "full_debounce", 2'd1, 4'b0001, 1'b0);
    expect_after(8, "reset_forward", 2'd1, 4'b0010, 1'b0);

    checks++;
    assert (sb.size() === 0) else begin
      failures++;
      $error("FAIL sb_drain: observed %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
